// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared state encodings, transfer type codes and helpers for mem_req_arbiter
package mem_req_arbiter_pkg;

  // Transfer size codes carried on rd_type / wr_type
  typedef enum logic [2:0] {
    TYPE_BYTE = 3'b000,
    TYPE_HALF = 3'b001,
    TYPE_WORD = 3'b010,
    TYPE_LINE = 3'b100
  } xfer_type_e;

  // Read channel FSM
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ISSUE  = 2'd1,
    R_WAIT_I = 2'd2,
    R_WAIT_D = 2'd3
  } rd_state_e;

  // Write channel FSM
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2
  } wr_state_e;

  // Consecutive data grants tolerated while the instruction side waits
  localparam logic [2:0] STREAK_LIMIT = 3'd4;

  // Two addresses fall in the same 16-byte (4-word) line
  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:4] == b[31:4];
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rd_arb_sel.sv
// rtl/mem_req_arbiter_rd_arb_sel.sv - read requester selection with data-first priority and instruction anti-starvation
module rd_arb_sel
  import mem_req_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_i_req,   // raw instruction request, used to track the starvation streak
  input  logic i_i_ok,    // instruction request present and hazard-free
  input  logic i_d_ok,    // data request present and hazard-free
  input  logic i_grant,   // read FSM consumes the current selection this cycle
  output logic o_valid,
  output logic o_sel_d
);

  logic [2:0] r_streak;
  logic       w_force_i;

  // Instruction wins once the data side has taken STREAK_LIMIT grants in a row
  assign w_force_i = i_i_ok && (r_streak >= STREAK_LIMIT);
  assign o_sel_d   = i_d_ok && !w_force_i;
  assign o_valid   = i_i_ok || i_d_ok;

  // Count data grants made while the instruction side was waiting; saturate at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= 3'd0;
    end else if (i_grant) begin
      if (!o_sel_d) begin
        r_streak <= 3'd0;
      end else if (i_i_req) begin
        r_streak <= (r_streak >= STREAK_LIMIT) ? STREAK_LIMIT : r_streak + 3'd1;
      end else begin
        r_streak <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - arbitrates icache/dcache reads and dcache writes onto one memory bus
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         rd_req,
  output logic [2:0]   rd_type,
  output logic [31:0]  rd_addr,
  input  logic         rd_rdy,
  input  logic         ret_valid,
  input  logic         ret_last,
  input  logic [31:0]  ret_data,
  output logic         wr_req,
  output logic [2:0]   wr_type,
  output logic [31:0]  wr_addr,
  output logic [3:0]   wr_wstrb,
  output logic [127:0] wr_data,
  input  logic         wr_rdy,
  input  logic         wr_bvalid
);

  rd_state_e     r_rd_state, w_rd_next;
  wr_state_e     r_wr_state, w_wr_next;
  logic          r_rd_own_d;
  logic [2:0]    r_rd_type;
  logic [31:0]   r_rd_addr;
  logic [2:0]    r_wr_type;
  logic [31:0]   r_wr_addr;
  logic [3:0]    r_wr_wstrb;
  logic [127:0]  r_wr_data;
  logic [1:0]    r_beat_cnt;
  logic          w_wr_guard;
  logic [31:0]   w_guard_addr;
  logic          w_i_ok, w_d_ok, w_sel_valid, w_sel_d, w_rd_grant, w_rd_waiting;

  // A write being accepted this cycle already blocks its line, so it wins a same-cycle race
  assign w_wr_guard   = (r_wr_state != W_IDLE) || d_wr_req;
  assign w_guard_addr = (r_wr_state == W_IDLE) ? d_wr_addr : r_wr_addr;
  assign w_i_ok       = i_rd_req && !(w_wr_guard && same_line(i_rd_addr, w_guard_addr));
  assign w_d_ok       = d_rd_req && !(w_wr_guard && same_line(d_rd_addr, w_guard_addr));
  assign w_rd_grant   = (r_rd_state == R_IDLE) && w_sel_valid;
  assign w_rd_waiting = (r_rd_state == R_WAIT_I) || (r_rd_state == R_WAIT_D);

  rd_arb_sel u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_i_req (i_rd_req),
    .i_i_ok  (w_i_ok),
    .i_d_ok  (w_d_ok),
    .i_grant (w_rd_grant),
    .o_valid (w_sel_valid),
    .o_sel_d (w_sel_d)
  );

  // State registers for both channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
    end
  end

  // Capture the winning read request at grant time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_own_d <= 1'b0;
      r_rd_type  <= 3'd0;
      r_rd_addr  <= 32'd0;
    end else if (w_rd_grant) begin
      r_rd_own_d <= w_sel_d;
      r_rd_type  <= w_sel_d ? d_rd_type : i_rd_type;
      r_rd_addr  <= w_sel_d ? d_rd_addr : i_rd_addr;
    end
  end

  // Capture the write request when the write channel is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_type  <= 3'd0;
      r_wr_addr  <= 32'd0;
      r_wr_wstrb <= 4'd0;
      r_wr_data  <= 128'd0;
    end else if ((r_wr_state == W_IDLE) && d_wr_req) begin
      r_wr_type  <= d_wr_type;
      r_wr_addr  <= d_wr_addr;
      r_wr_wstrb <= d_wr_wstrb;
      r_wr_data  <= d_wr_data;
    end
  end

  // Track return beats of the current burst; the last beat restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= 2'd0;
    end else if (w_rd_waiting && ret_valid) begin
      r_beat_cnt <= ret_last ? 2'd0 : r_beat_cnt + 2'd1;
    end
  end

  // Read FSM next state, bus request and response routing to the owner
  always_comb begin
    w_rd_next   = r_rd_state;
    rd_req      = 1'b0;
    rd_type     = 3'd0;
    rd_addr     = 32'd0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    i_ret_data  = 32'd0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    d_ret_data  = 32'd0;
    case (r_rd_state)
      R_IDLE: begin
        if (w_rd_grant) w_rd_next = R_ISSUE;
      end
      R_ISSUE: begin
        rd_req  = 1'b1;
        rd_type = r_rd_type;
        rd_addr = r_rd_addr;
        if (rd_rdy) begin
          d_rd_rdy  = r_rd_own_d;
          i_rd_rdy  = !r_rd_own_d;
          w_rd_next = r_rd_own_d ? R_WAIT_D : R_WAIT_I;
        end
      end
      R_WAIT_I: begin
        i_ret_valid = ret_valid;
        i_ret_last  = ret_last;
        i_ret_data  = ret_data;
        if (ret_valid && ret_last) w_rd_next = R_IDLE;
      end
      R_WAIT_D: begin
        d_ret_valid = ret_valid;
        d_ret_last  = ret_last;
        d_ret_data  = ret_data;
        if (ret_valid && ret_last) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Write FSM next state and bus request
  always_comb begin
    w_wr_next = r_wr_state;
    wr_req    = 1'b0;
    wr_type   = 3'd0;
    wr_addr   = 32'd0;
    wr_wstrb  = 4'd0;
    wr_data   = 128'd0;
    d_wr_rdy  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (d_wr_req) w_wr_next = W_ISSUE;
      end
      W_ISSUE: begin
        wr_req   = 1'b1;
        wr_type  = r_wr_type;
        wr_addr  = r_wr_addr;
        wr_wstrb = r_wr_wstrb;
        wr_data  = r_wr_data;
        if (wr_rdy) begin
          d_wr_rdy  = 1'b1;
          w_wr_next = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_bvalid) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic i_rd_req; logic [2:0] i_rd_type; logic [31:0] i_rd_addr;
  logic i_rd_rdy, i_ret_valid, i_ret_last; logic [31:0] i_ret_data;
  logic d_rd_req; logic [2:0] d_rd_type; logic [31:0] d_rd_addr;
  logic d_rd_rdy, d_ret_valid, d_ret_last; logic [31:0] d_ret_data;
  logic d_wr_req; logic [2:0] d_wr_type; logic [31:0] d_wr_addr; logic [3:0] d_wr_wstrb;
  logic [127:0] d_wr_data; logic d_wr_rdy;
  logic rd_req; logic [2:0] rd_type; logic [31:0] rd_addr;
  logic rd_rdy, ret_valid, ret_last; logic [31:0] ret_data;
  logic wr_req; logic [2:0] wr_type; logic [31:0] wr_addr; logic [3:0] wr_wstrb;
  logic [127:0] wr_data; logic wr_rdy, wr_bvalid;

  typedef struct { bit own_d; logic [31:0] addr; logic [2:0] typ; } rd_exp_t;
  typedef struct { logic [31:0] addr; logic [2:0] typ; logic [3:0] strb; logic [127:0] data; } wr_exp_t;
  rd_exp_t exp_q[$];
  wr_exp_t wexp_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_bvalid(wr_bvalid)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic req_rd(input bit own_d, input logic [31:0] addr, input logic [2:0] typ);
    rd_exp_t e;
    if (own_d) begin d_rd_req = 1'b1; d_rd_addr = addr; d_rd_type = typ; end
    else       begin i_rd_req = 1'b1; i_rd_addr = addr; i_rd_type = typ; end
    e.own_d = own_d; e.addr = addr; e.typ = typ;
    exp_q.push_back(e);
  endtask

  task automatic req_wr(input logic [31:0] addr, input logic [127:0] data);
    wr_exp_t w;
    d_wr_req = 1'b1; d_wr_addr = addr; d_wr_type = TYPE_LINE; d_wr_wstrb = 4'hF; d_wr_data = data;
    w.addr = addr; w.typ = TYPE_LINE; w.strb = 4'hF; w.data = data;
    wexp_q.push_back(w);
  endtask

  // Memory-side model for one read: accept the issue, then return nbeats beats of 0xA0+n
  task automatic serve_rd(input int nbeats, input bit drop, input int abort_at, output int waits);
    rd_exp_t e;
    waits = 0;
    if (exp_q.size() == 0) begin chk("rd_sb_empty", 0, 1); return; end
    e = exp_q.pop_front();
    while (!rd_req && waits < 20) begin @(negedge clk); waits++; end
    chk("rd_req_seen", rd_req, 1);
    if (!rd_req) return;
    chk("rd_addr", rd_addr, e.addr);
    chk("rd_type", rd_type, e.typ);
    rd_rdy = 1'b1; #1;
    chk("own_rd_rdy", e.own_d ? d_rd_rdy : i_rd_rdy, 1);
    chk("oth_rd_rdy", e.own_d ? i_rd_rdy : d_rd_rdy, 0);
    if (drop) begin if (e.own_d) d_rd_req = 1'b0; else i_rd_req = 1'b0; end
    @(negedge clk); rd_rdy = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_at) return;
      chk("rd_req_in_wait", rd_req, 0);
      ret_valid = 1'b1; ret_last = (b == nbeats - 1); ret_data = 32'hA0 + b; #1;
      chk("own_ret_valid", e.own_d ? d_ret_valid : i_ret_valid, 1);
      chk("own_ret_last", e.own_d ? d_ret_last : i_ret_last, (b == nbeats - 1));
      chk("own_ret_data", e.own_d ? d_ret_data : i_ret_data, 32'hA0 + b);
      chk("oth_ret_valid", e.own_d ? i_ret_valid : d_ret_valid, 0);
      @(negedge clk); ret_valid = 1'b0; ret_last = 1'b0;
    end
    chk("idle_gap_no_rd_req", rd_req, 0);
  endtask

  // Memory-side model for one write issue
  task automatic serve_wr();
    wr_exp_t w;
    int waits = 0;
    if (wexp_q.size() == 0) begin chk("wr_sb_empty", 0, 1); return; end
    w = wexp_q.pop_front();
    while (!wr_req && waits < 20) begin @(negedge clk); waits++; end
    chk("wr_req_seen", wr_req, 1);
    chk("wr_addr", wr_addr, w.addr);
    chk("wr_type", wr_type, w.typ);
    chk("wr_wstrb", wr_wstrb, w.strb);
    chk("wr_data", wr_data, w.data);
    wr_rdy = 1'b1; #1;
    chk("d_wr_rdy", d_wr_rdy, 1);
    d_wr_req = 1'b0;
    @(negedge clk); wr_rdy = 1'b0;
  endtask

  task automatic hold_blocked(input int cycles, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (rd_req) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  task automatic bvalid_pulse();
    wr_bvalid = 1'b1;
    @(negedge clk);
    wr_bvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit own_seq [6];
    bit drop_seq [6];
    own_seq  = '{1, 1, 1, 1, 0, 1};
    drop_seq = '{0, 0, 0, 0, 1, 1};
    rst = 1'b1;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
    rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
    wr_rdy = 0; wr_bvalid = 0;
    repeat (2) @(negedge clk);

    // Reset state: everything quiet even with ret_valid driven
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_i_ret_valid", i_ret_valid, 0);
    chk("rst_d_ret_valid", d_ret_valid, 0);
    chk("rst_d_ret_data", d_ret_data, 0);
    chk("rst_rdys", {i_rd_rdy, d_rd_rdy, d_wr_rdy}, 0);
    chk("rst_beat_cnt", dut.r_beat_cnt, 0);
    ret_valid = 0; ret_last = 0; ret_data = 0;
    rst = 1'b0;
    @(negedge clk);

    // Both sides request together: data first, instruction after data's last beat
    req_rd(1'b0, 32'h1FC0_0000, TYPE_WORD);
    req_rd(1'b1, 32'h0000_0100, TYPE_WORD);
    exp_q.push_front(exp_q.pop_back());
    serve_rd(1, 1'b1, -1, w);
    serve_rd(1, 1'b1, -1, w);

    // Both held continuously: D,D,D,D,I then D again once the streak is cleared
    i_rd_req = 1'b1; i_rd_addr = 32'h1FC0_0040; i_rd_type = TYPE_WORD;
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_0140; d_rd_type = TYPE_WORD;
    for (int k = 0; k < 6; k++) begin
      rd_exp_t e;
      e.own_d = own_seq[k];
      e.addr  = own_seq[k] ? 32'h0000_0140 : 32'h1FC0_0040;
      e.typ   = TYPE_WORD;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 6; k++) serve_rd(1, drop_seq[k], -1, w);
    @(negedge clk);

    // Line read: four beats, last on the fourth, beat counter back to 0
    req_rd(1'b1, 32'h0000_0500, TYPE_LINE);
    serve_rd(4, 1'b1, -1, w);
    chk("beat_cnt_after_line", dut.r_beat_cnt, 0);

    // Write line 0x200 pending: unrelated read 0x300 proceeds, same-line read 0x20C waits
    req_wr(32'h0000_0200, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    req_rd(1'b1, 32'h0000_0300, TYPE_WORD);
    @(negedge clk);
    chk("rd_300_concurrent", rd_req, 1);
    serve_wr();
    serve_rd(1, 1'b1, -1, w);
    chk("rd_300_no_wait", w, 0);
    req_rd(1'b1, 32'h0000_020C, TYPE_WORD);
    hold_blocked(6, "rd_20c_blocked");
    bvalid_pulse();
    serve_rd(1, 1'b1, -1, w);

    // Write and read to the same line in one cycle: write goes first, read waits
    req_wr(32'h0000_0400, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
    req_rd(1'b1, 32'h0000_0408, TYPE_WORD);
    @(negedge clk);
    chk("same_cycle_rd_blocked", rd_req, 0);
    serve_wr();
    hold_blocked(3, "rd_408_blocked");
    bvalid_pulse();
    serve_rd(1, 1'b1, -1, w);

    // Reset during the second beat of a data line read
    req_rd(1'b1, 32'h0000_0600, TYPE_LINE);
    serve_rd(4, 1'b1, 1, w);
    ret_valid = 1'b1; ret_data = 32'hA1; rst = 1'b1; #1;
    chk("rst_mid_d_ret_valid", d_ret_valid, 0);
    @(negedge clk);
    chk("rst_mid_outputs", {rd_req, wr_req, d_rd_rdy, i_rd_rdy, d_ret_valid, i_ret_valid, d_wr_rdy}, 0);
    chk("rst_mid_beat_cnt", dut.r_beat_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_no_fwd", {d_ret_valid, i_ret_valid, rd_req}, 0);
    ret_valid = 1'b0;
    @(negedge clk);

    chk("rd_sb_drained", exp_q.size(), 0);
    chk("wr_sb_drained", wexp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
